logfbe_log2: RTL



---
 rtl/logfbe_log2.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/logfbe_log2.sv
// Fixed-point log2 for the MFCC front end: 32-bit filter-bank energy -> Q5.11 log value.
// Define LOGFBE_LUT_CORR_EN to add stage S4 (mantissa correction ROM, latency 4 instead of 3).
module logfbe_log2 #(
    parameter int NUM_FILT = 26,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] fbe_data,
    input  logic        fbe_valid,
    input  logic        fbe_last,
    output logic        fbe_ready,
    output logic [15:0] wr_data,
    output logic        wr_en,
    input  logic        almost_full,
    input  logic        full,
    output logic        busy,
    output logic        frame_done,
    output logic        ovf_err,
    output logic        frm_err
);

`ifdef LOGFBE_LUT_CORR_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NUM_FILT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    typedef struct packed {
        logic [4:0]  p;
        logic [10:0] m;
    } norm_t;

    state_t           state, state_nxt;
    logic             accept, cnt_end, eff_last, out_vld, out_last;
    logic [CNT_W-1:0] cnt;
    // vld_pipe[0] = S1 holds data, vld_pipe[STAGES] = result at the FIFO port
    logic [STAGES:0]  vld_pipe, last_pipe;
    logic [31:0]      s1_data, norm;
    logic [4:0]       lod_p;
    norm_t            s2;
    logic [15:0]      s3_res, out_res;

    assign accept   = fbe_valid && fbe_ready;
    assign cnt_end  = (cnt == CNT_END);
    // A full count forces the frame to end even without fbe_last
    assign eff_last = fbe_last || cnt_end;
    assign out_vld  = vld_pipe[STAGES];
    assign out_last = last_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && eff_last) state_nxt = DRAIN;
            DRAIN:   if (out_vld && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        fbe_ready = (state == RUN) && !almost_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (accept) cnt <= eff_last ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            if (accept && (fbe_last != cnt_end)) frm_err <= 1'b1;
            if (out_vld && full)                 ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
            last_pipe <= {last_pipe[STAGES-1:0], accept && eff_last};
        end
    end

    // Leading-one detect; x==0 yields p=0 and norm=0, so the result is 0x0000 with no special case
    always_comb begin
        lod_p = '0;
        for (int i = 0; i < 32; i++)
            if (s1_data[i]) lod_p = 5'(i);
        norm = s1_data << (5'd31 - lod_p);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data <= '0;
            s2      <= '0;
            s3_res  <= '0;
        end else begin
            if (accept)      s1_data <= fbe_data;
            if (vld_pipe[0]) s2      <= '{p: lod_p, m: norm[30:20]};
            if (vld_pipe[1]) s3_res  <= {s2.p, s2.m};
        end
    end

`ifdef LOGFBE_LUT_CORR_EN
    logic [7:0]  corr;
    logic [16:0] corr_sum;
    logic [15:0] s4_res;

    // round(2048*(log2(1+i/16) - i/16)), indexed by the top 4 mantissa bits
    always_comb begin
        case (s3_res[10:7])
            4'd0:  corr = 8'd0;
            4'd1:  corr = 8'd51;
            4'd2:  corr = 8'd92;
            4'd3:  corr = 8'd124;
            4'd4:  corr = 8'd147;
            4'd5:  corr = 8'd163;
            4'd6:  corr = 8'd173;
            4'd7:  corr = 8'd176;
            4'd8:  corr = 8'd174;
            4'd9:  corr = 8'd167;
            4'd10: corr = 8'd154;
            4'd11: corr = 8'd138;
            4'd12: corr = 8'd117;
            4'd13: corr = 8'd93;
            4'd14: corr = 8'd65;
            default: corr = 8'd34;
        endcase
        corr_sum = {1'b0, s3_res} + {9'd0, corr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           s4_res <= '0;
        else if (vld_pipe[2]) s4_res <= corr_sum[16] ? 16'hFFFF : corr_sum[15:0];
    end

    assign out_res = s4_res;
`else
    assign out_res = s3_res;
`endif

    // A result that meets a full FIFO is dropped rather than stalling the pipe
    assign wr_en      = out_vld && !full;
    assign wr_data    = out_res;
    assign frame_done = out_vld && out_last;

endmodule
